axis_frame_arbiter: RTL and testbench

- Frame-granular round-robin arbiter multiplexing PORTS 64-bit AXI-stream sources onto one 64-bit AXI-stream output.
- The output feeds the 64→8 axis_adapter width converter, so several producers can share one adapter/narrow link.
- Once a port is granted, its whole frame (through tlast) passes without interleaving.
- A registered output stage with a one-beat skid buffer breaks every combinational path from output_axis_tready to input_axis_tready.

---
 rtl/axis_frame_arbiter.sv | 144 ++++++++++++++
 tb/tb_axis_frame_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_arbiter.sv
// Frame-granular round-robin arbiter: PORTS AXI-stream sources share one output.
// A registered output stage with a one-beat skid buffer isolates output ready from input ready.
`timescale 1ns/1ps
module axis_frame_arbiter #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int SEL_WIDTH  = $clog2(PORTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PORTS*DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [PORTS*KEEP_WIDTH-1:0] input_axis_tkeep,
  input  logic [PORTS-1:0]            input_axis_tvalid,
  output logic [PORTS-1:0]            input_axis_tready,
  input  logic [PORTS-1:0]            input_axis_tlast,
  input  logic [PORTS-1:0]            input_axis_tuser,
  output logic [DATA_WIDTH-1:0]       output_axis_tdata,
  output logic [KEEP_WIDTH-1:0]       output_axis_tkeep,
  output logic                        output_axis_tvalid,
  input  logic                        output_axis_tready,
  output logic                        output_axis_tlast,
  output logic                        output_axis_tuser,
  output logic [SEL_WIDTH-1:0]        grant_index,
  output logic                        grant_valid
);

  // Valid/ready: a beat moves on a rising edge where valid and ready are both 1;
  // valid and payload stay stable until then, and ready never depends on valid combinationally.
  localparam int BEAT_W = DATA_WIDTH + KEEP_WIDTH + 2;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [SEL_WIDTH-1:0] grant_q, grant_d;
  logic [SEL_WIDTH-1:0] last_grant_q, last_grant_d;
  logic                 ready_int_q, ready_int_d;
  logic [BEAT_W-1:0]    out_beat_q, out_beat_d;
  logic [BEAT_W-1:0]    tmp_beat_q, tmp_beat_d;
  logic                 out_valid_q, out_valid_d;
  logic                 tmp_valid_q, tmp_valid_d;
  logic [BEAT_W-1:0]    mux_beat;
  logic                 mux_valid;
  logic                 accept;
  logic                 found;

  // Arbiter: round-robin scan in IDLE, frame lock in ACTIVE.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    found        = 1'b0;
    mux_beat     = '0;
    mux_valid    = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      if (grant_q == SEL_WIDTH'(p)) begin
        mux_beat  = {input_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH],
                     input_axis_tkeep[p*KEEP_WIDTH +: KEEP_WIDTH],
                     input_axis_tlast[p], input_axis_tuser[p]};
        mux_valid = input_axis_tvalid[p];
      end
    end
    accept = (state_q == ACTIVE) && mux_valid && ready_int_q;
    case (state_q)
      IDLE: begin
        for (int i = 1; i <= PORTS; i++) begin
          for (int p = 0; p < PORTS; p++) begin
            if (!found && input_axis_tvalid[p] && (p == (int'(last_grant_q) + i) % PORTS)) begin
              found   = 1'b1;
              grant_d = SEL_WIDTH'(p);
            end
          end
        end
        if (found) begin
          state_d      = ACTIVE;
          last_grant_d = grant_d;
        end
      end
      ACTIVE: if (accept && mux_beat[1]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output register plus skid slot; the skid slot absorbs the beat accepted while ready falls.
  always_comb begin
    ready_int_d = output_axis_tready | (!tmp_valid_q & (!out_valid_q | !accept));
    out_valid_d = out_valid_q;
    out_beat_d  = out_beat_q;
    tmp_valid_d = tmp_valid_q;
    tmp_beat_d  = tmp_beat_q;
    if (ready_int_q) begin
      if (output_axis_tready || !out_valid_q) begin
        out_valid_d = accept;
        if (accept) out_beat_d = mux_beat;
      end else begin
        tmp_valid_d = accept;
        if (accept) tmp_beat_d = mux_beat;
      end
    end else if (output_axis_tready) begin
      out_valid_d = tmp_valid_q;
      out_beat_d  = tmp_beat_q;
      tmp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= SEL_WIDTH'(PORTS - 1);
      ready_int_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_beat_q   <= '0;
      tmp_valid_q  <= 1'b0;
      tmp_beat_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ready_int_q  <= ready_int_d;
      out_valid_q  <= out_valid_d;
      out_beat_q   <= out_beat_d;
      tmp_valid_q  <= tmp_valid_d;
      tmp_beat_q   <= tmp_beat_d;
    end
  end

  always_comb begin
    input_axis_tready = '0;
    for (int p = 0; p < PORTS; p++) begin
      if ((state_q == ACTIVE) && (grant_q == SEL_WIDTH'(p))) input_axis_tready[p] = ready_int_q;
    end
  end

  // grant_valid is the FSM state itself (1 = ACTIVE).
  assign grant_valid        = (state_q == ACTIVE);
  assign grant_index        = grant_q;
  assign output_axis_tvalid = out_valid_q;
  assign output_axis_tdata  = out_beat_q[BEAT_W-1 -: DATA_WIDTH];
  assign output_axis_tkeep  = out_beat_q[KEEP_WIDTH+1 : 2];
  assign output_axis_tlast  = out_beat_q[1];
  assign output_axis_tuser  = out_beat_q[0];

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Directed bench for axis_frame_arbiter: per-port source queues, output monitor and
// an in-order scoreboard of {tdata, tkeep, tlast, tuser} beats.
`timescale 1ns/1ps
module tb_axis_frame_arbiter;

  localparam int BW = 64 + 8 + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [255:0] input_axis_tdata;
  logic [31:0]  input_axis_tkeep;
  logic [3:0]   input_axis_tvalid;
  logic [3:0]   input_axis_tready;
  logic [3:0]   input_axis_tlast;
  logic [3:0]   input_axis_tuser;
  logic [63:0]  output_axis_tdata;
  logic [7:0]   output_axis_tkeep;
  logic         output_axis_tvalid;
  logic         output_axis_tready = 1'b1;
  logic         output_axis_tlast;
  logic         output_axis_tuser;
  logic [1:0]   grant_index;
  logic         grant_valid;

  logic [63:0] in_data_a [4];
  logic [7:0]  in_keep_a [4];
  logic        in_valid_a[4];
  logic        in_last_a [4];
  logic        in_user_a [4];
  logic        hs        [4];

  logic [BW-1:0] src_mem [4][64];
  int            src_head[4] = '{default: 0};
  int            src_tail[4] = '{default: 0};
  int            acc     [4] = '{default: 0};
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] obs_q[$];
  int            checks = 0;
  int            failures = 0;

  assign input_axis_tdata  = {in_data_a[3], in_data_a[2], in_data_a[1], in_data_a[0]};
  assign input_axis_tkeep  = {in_keep_a[3], in_keep_a[2], in_keep_a[1], in_keep_a[0]};
  assign input_axis_tvalid = {in_valid_a[3], in_valid_a[2], in_valid_a[1], in_valid_a[0]};
  assign input_axis_tlast  = {in_last_a[3], in_last_a[2], in_last_a[1], in_last_a[0]};
  assign input_axis_tuser  = {in_user_a[3], in_user_a[2], in_user_a[1], in_user_a[0]};

  axis_frame_arbiter #(.PORTS(4), .DATA_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .input_axis_tdata(input_axis_tdata), .input_axis_tkeep(input_axis_tkeep),
    .input_axis_tvalid(input_axis_tvalid), .input_axis_tready(input_axis_tready),
    .input_axis_tlast(input_axis_tlast), .input_axis_tuser(input_axis_tuser),
    .output_axis_tdata(output_axis_tdata), .output_axis_tkeep(output_axis_tkeep),
    .output_axis_tvalid(output_axis_tvalid), .output_axis_tready(output_axis_tready),
    .output_axis_tlast(output_axis_tlast), .output_axis_tuser(output_axis_tuser),
    .grant_index(grant_index), .grant_valid(grant_valid)
  );

  // Clock
  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Source driver and output monitor: handshakes sampled mid-cycle, sources advance at posedge+1.
  initial begin : driver
    for (int p = 0; p < 4; p++) begin
      in_data_a[p] = '0; in_keep_a[p] = '0; in_valid_a[p] = 1'b0;
      in_last_a[p] = 1'b0; in_user_a[p] = 1'b0; hs[p] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int p = 0; p < 4; p++) hs[p] = in_valid_a[p] && input_axis_tready[p];
      if (output_axis_tvalid && output_axis_tready)
        obs_q.push_back({output_axis_tdata, output_axis_tkeep, output_axis_tlast, output_axis_tuser});
      @(posedge clk);
      #1;
      for (int p = 0; p < 4; p++) begin
        if (hs[p]) begin
          src_head[p]++;
          acc[p]++;
        end
        if (src_head[p] < src_tail[p]) begin
          {in_data_a[p], in_keep_a[p], in_last_a[p], in_user_a[p]} = src_mem[p][src_head[p]];
          in_valid_a[p] = 1'b1;
        end else begin
          {in_data_a[p], in_keep_a[p], in_last_a[p], in_user_a[p]} = '0;
          in_valid_a[p] = 1'b0;
        end
      end
    end
  end

  function automatic logic [63:0] mk(input logic [7:0] b);
    return {8{b}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_frame(input int p, input logic [7:0] b0, input int n,
                            input logic [7:0] k, input logic u);
    for (int i = 0; i < n; i++) begin
      src_mem[p][src_tail[p]] = {mk(b0 + 8'(i)), k, (i == n - 1), u};
      src_tail[p]++;
    end
  endtask

  task automatic exp_frame(input logic [7:0] b0, input int n, input logic [7:0] k, input logic u);
    for (int i = 0; i < n; i++) exp_q.push_back({mk(b0 + 8'(i)), k, (i == n - 1), u});
  endtask

  task automatic sb_check(input string tag);
    int n;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_beat%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    int  n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < 300) begin
      step();
      n++;
      done = !output_axis_tvalid && !grant_valid;
      for (int p = 0; p < 4; p++) if (src_head[p] != src_tail[p]) done = 1'b0;
    end
    chk({tag, "_drain"}, done, 1'b1);
  endtask

  task automatic wait_acc(input int p, input int target, input string tag);
    int n;
    n = 0;
    while (acc[p] < target && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_acc_wait"}, (acc[p] >= target), 1'b1);
  endtask

  task automatic flush();
    for (int p = 0; p < 4; p++) src_head[p] = src_tail[p];
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    flush();
    step();
    rst_n = 1'b1;
  endtask

  initial begin : main
    int base;
    int n;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tvalid", output_axis_tvalid, 1'b0);
    chk("rst_grant_valid", grant_valid, 1'b0);
    chk("rst_tready", input_axis_tready, 4'h0);
    chk("rst_grant_index", grant_index, 2'd0);
    chk("rst_tdata", output_axis_tdata, 64'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // 1: single 3-beat frame on port 2
    push_frame(2, 8'h01, 3, 8'hFF, 1'b0);
    exp_frame(8'h01, 3, 8'hFF, 1'b0);
    step();
    chk("t1_gv_before", grant_valid, 1'b0);
    step();
    chk("t1_gv", grant_valid, 1'b1);
    chk("t1_gi", grant_index, 2'd2);
    chk("t1_ov_before", output_axis_tvalid, 1'b0);
    step();
    chk("t1_b1_valid", output_axis_tvalid, 1'b1);
    chk("t1_b1_data", output_axis_tdata, 64'h0101010101010101);
    chk("t1_b1_last", output_axis_tlast, 1'b0);
    step();
    chk("t1_b2_valid", output_axis_tvalid, 1'b1);
    chk("t1_b2_data", output_axis_tdata, 64'h0202020202020202);
    step();
    chk("t1_b3_data", output_axis_tdata, 64'h0303030303030303);
    chk("t1_b3_last", output_axis_tlast, 1'b1);
    chk("t1_gv_after", grant_valid, 1'b0);
    step();
    chk("t1_ov_after", output_axis_tvalid, 1'b0);
    sb_check("t1");

    // 2: round robin 0,3 then 0,1
    do_reset();
    step();
    push_frame(0, 8'hA0, 2, 8'hFF, 1'b0);
    push_frame(3, 8'hB0, 2, 8'hFF, 1'b1);
    exp_frame(8'hA0, 2, 8'hFF, 1'b0);
    exp_frame(8'hB0, 2, 8'hFF, 1'b1);
    step();
    step();
    chk("t2_first_gi", grant_index, 2'd0);
    wait_idle("t2a");
    push_frame(0, 8'hC0, 2, 8'hFF, 1'b0);
    push_frame(1, 8'hD0, 2, 8'hFF, 1'b0);
    exp_frame(8'hC0, 2, 8'hFF, 1'b0);
    exp_frame(8'hD0, 2, 8'hFF, 1'b0);
    step();
    step();
    chk("t2_second_gi", grant_index, 2'd0);
    wait_idle("t2b");
    sb_check("t2");

    // 3: 4-cycle downstream stall during a 6-beat frame
    push_frame(0, 8'h30, 6, 8'hFF, 1'b0);
    exp_frame(8'h30, 6, 8'hFF, 1'b0);
    n = 0;
    do begin
      step();
      n++;
    end while (!output_axis_tvalid && n < 50);
    chk("t3_start", output_axis_tvalid, 1'b1);
    output_axis_tready = 1'b0;
    base = acc[0];
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t3_hold_valid%0d", i), output_axis_tvalid, 1'b1);
      chk($sformatf("t3_hold_data%0d", i), output_axis_tdata, 64'h3030303030303030);
    end
    chk("t3_tready_low", input_axis_tready[0], 1'b0);
    chk("t3_acc_le2", ((acc[0] - base) <= 2), 1'b1);
    output_axis_tready = 1'b1;
    wait_idle("t3");
    sb_check("t3");

    // 4: port 1 requests mid-frame of port 0
    base = acc[0];
    push_frame(0, 8'h40, 4, 8'hFF, 1'b0);
    exp_frame(8'h40, 4, 8'hFF, 1'b0);
    wait_acc(0, base + 1, "t4_b1");
    push_frame(1, 8'h50, 2, 8'hFF, 1'b1);
    exp_frame(8'h50, 2, 8'hFF, 1'b1);
    wait_acc(0, base + 4, "t4_last");
    chk("t4_gap_gv", grant_valid, 1'b0);
    step();
    chk("t4_next_gv", grant_valid, 1'b1);
    chk("t4_next_gi", grant_index, 2'd1);
    wait_idle("t4");
    sb_check("t4");

    // 5: asynchronous reset mid-frame
    base = acc[2];
    push_frame(2, 8'h60, 5, 8'hFF, 1'b0);
    wait_acc(2, base + 2, "t5_two");
    #1 rst_n = 1'b0;
    #1;
    chk("t5_async_ov", output_axis_tvalid, 1'b0);
    chk("t5_async_gv", grant_valid, 1'b0);
    chk("t5_async_tready", input_axis_tready, 4'h0);
    chk("t5_partial_count", obs_q.size(), 1);
    chk("t5_partial_beat", obs_q[0], {mk(8'h60), 8'hFF, 1'b0, 1'b0});
    step();
    flush();
    step();
    rst_n = 1'b1;
    push_frame(2, 8'h80, 2, 8'hFF, 1'b0);
    push_frame(0, 8'h70, 2, 8'hFF, 1'b0);
    exp_frame(8'h70, 2, 8'hFF, 1'b0);
    exp_frame(8'h80, 2, 8'hFF, 1'b0);
    step();
    step();
    chk("t5_winner_gi", grant_index, 2'd0);
    wait_idle("t5");
    sb_check("t5");

    // 6: all four ports, single-beat frames, partial keep, alternating user
    do_reset();
    for (int p = 0; p < 4; p++) push_frame(p, 8'h90 + 8'(p), 1, 8'h1F, p[0]);
    for (int p = 0; p < 4; p++) exp_frame(8'h90 + 8'(p), 1, 8'h1F, p[0]);
    wait_idle("t6");
    sb_check("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
